// File: rtl/alu_seq_if.sv
// Request/response bundle between operand fetch, the sequential ALU and writeback.
// Signal names follow the ALU's established port names.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALUOp;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Result;
    logic             Zero;
    logic             Carry;
    logic             Overflow;
    logic             Illegal;

    modport master (
        output in_valid, A, B, ALUOp, out_ready,
        input  in_ready, out_valid, Result, Zero, Carry, Overflow, Illegal
    );

    modport slave (
        input  in_valid, A, B, ALUOp, out_ready,
        output in_ready, out_valid, Result, Zero, Carry, Overflow, Illegal
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU with a registered result and status flags, a valid/ready handshake on both sides,
// and an iterative shift-add multiplier that takes WIDTH cycles.
module alu_seq #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned MUL_EN = 1
) (
    input logic      clk,
    input logic      rst_n,
    alu_seq_if.slave bus
);
    localparam int unsigned SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CntLast = SHW'(WIDTH - 1);

    localparam logic [3:0] OpAdd  = 4'd0;
    localparam logic [3:0] OpAnd  = 4'd1;
    localparam logic [3:0] OpOr   = 4'd2;
    localparam logic [3:0] OpNor  = 4'd3;
    localparam logic [3:0] OpSub  = 4'd4;
    localparam logic [3:0] OpXor  = 4'd5;
    localparam logic [3:0] OpSlt  = 4'd6;
    localparam logic [3:0] OpSltu = 4'd7;
    localparam logic [3:0] OpSll  = 4'd8;
    localparam logic [3:0] OpSrl  = 4'd9;
    localparam logic [3:0] OpSra  = 4'd10;
    localparam logic [3:0] OpMul  = 4'd11;

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    state_e             state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;
    logic               illegal_q, illegal_d;

    logic [WIDTH:0]     sum_add, sum_sub;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_v, alu_ill, is_mul;
    logic [2*WIDTH-1:0] acc_next;

    // Single-cycle datapath, evaluated on the live request operands at accept.
    always_comb begin
        sum_add = {1'b0, bus.A} + {1'b0, bus.B};
        sum_sub = {1'b0, bus.A} + {1'b0, ~bus.B} + {{WIDTH{1'b0}}, 1'b1};
        shamt   = bus.B[SHW-1:0];
        is_mul  = (bus.ALUOp == OpMul) && (MUL_EN != 0);
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (bus.ALUOp)
            OpAdd: begin
                alu_res = sum_add[WIDTH-1:0];
                alu_c   = sum_add[WIDTH];
                alu_v   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                          (sum_add[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OpSub: begin
                alu_res = sum_sub[WIDTH-1:0];
                alu_c   = sum_sub[WIDTH];
                alu_v   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                          (sum_sub[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OpAnd:   alu_res = bus.A & bus.B;
            OpOr:    alu_res = bus.A | bus.B;
            OpNor:   alu_res = ~(bus.A | bus.B);
            OpXor:   alu_res = bus.A ^ bus.B;
            OpSlt:   alu_res = WIDTH'($signed(bus.A) < $signed(bus.B));
            OpSltu:  alu_res = WIDTH'(bus.A < bus.B);
            OpSll:   alu_res = bus.A << shamt;
            OpSrl:   alu_res = bus.A >> shamt;
            OpSra:   alu_res = $unsigned($signed(bus.A) >>> shamt);
            OpMul:   alu_ill = (MUL_EN == 0);
            default: alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        illegal_d = illegal_q;
        acc_next  = acc_q + (mplier_q[0] ? mcand_q : '0);
        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    if (is_mul) begin
                        acc_d     = '0;
                        mcand_d   = {{WIDTH{1'b0}}, bus.A};
                        mplier_d  = bus.B;
                        cnt_d     = '0;
                        illegal_d = 1'b0;
                        state_d   = StMul;
                    end else begin
                        result_d  = alu_res;
                        zero_d    = (alu_res == '0) && !alu_ill;
                        carry_d   = alu_c;
                        ovf_d     = alu_v;
                        illegal_d = alu_ill;
                        state_d   = StDone;
                    end
                end
            end
            StMul: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    result_d = acc_next[WIDTH-1:0];
                    zero_d   = (acc_next[WIDTH-1:0] == '0);
                    carry_d  = 1'b0;
                    ovf_d    = |acc_next[2*WIDTH-1:WIDTH];
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    illegal_d = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
            ovf_q     <= ovf_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.in_ready  = rst_n && (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.Result    = result_q;
    assign bus.Zero      = zero_q;
    assign bus.Carry     = carry_q;
    assign bus.Overflow  = ovf_q;
    assign bus.Illegal   = illegal_q;
endmodule
